// File: rtl/invert_search.sv
// Inverse-function search: finds x with f(x) == y by linear scan (MODE=0)
// or by binary search over a nondecreasing f (MODE=1).
module invert_search #(
  parameter int WIDTH = 8,
  parameter int MODE  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] probe_x,
  input  logic [WIDTH-1:0] f_y,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic [WIDTH-1:0] x,
  output logic [WIDTH:0]   probes
);

  localparam bit               BIN   = (MODE != 0);
  localparam logic [WIDTH-1:0] MAX_C = {WIDTH{1'b1}};
  localparam logic [WIDTH:0]   MAX_V = {1'b0, {WIDTH{1'b1}}};
  localparam logic [WIDTH:0]   ONE_V = {{WIDTH{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEARCH = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [WIDTH:0]   lo_q, lo_d, hi_q, hi_d;
  logic             found_q, found_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH:0]   probes_q, probes_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Bounds are kept one bit wider so mid+1 / mid-1 and lo+hi never wrap.
  logic [WIDTH:0] mid_s, lo_inc_s, hi_dec_s;
  assign mid_s    = {1'b0, cand_q};
  assign lo_inc_s = mid_s + ONE_V;
  assign hi_dec_s = mid_s - ONE_V;

  // Next-state, search bookkeeping and result capture.
  always_comb begin
    state_d  = state_q;
    y_d      = y_q;
    cand_d   = cand_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    found_d  = found_q;
    x_d      = x_q;
    probes_d = probes_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_SEARCH;
          y_d      = y;
          found_d  = 1'b0;
          x_d      = {WIDTH{1'b0}};
          probes_d = {(WIDTH+1){1'b0}};
          lo_d     = {(WIDTH+1){1'b0}};
          hi_d     = MAX_V;
          cand_d   = BIN ? WIDTH'(MAX_V >> 1) : {WIDTH{1'b0}};
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SEARCH: begin
        probes_d = probes_q + ONE_V;
        if (f_y == y_q) begin
          state_d = S_DONE;
          found_d = 1'b1;
          x_d     = cand_q;
        end else if (!BIN) begin
          if (cand_q == MAX_C) begin
            state_d = S_DONE;
            found_d = 1'b0;
            x_d     = {WIDTH{1'b0}};
          end else begin
            cand_d = cand_q + {{(WIDTH-1){1'b0}}, 1'b1};
          end
        end else if (f_y < y_q) begin
          if ((cand_q == MAX_C) || (lo_inc_s > hi_q)) begin
            state_d = S_DONE;
            found_d = 1'b0;
            x_d     = {WIDTH{1'b0}};
          end else begin
            lo_d   = lo_inc_s;
            cand_d = WIDTH'((lo_inc_s + hi_q) >> 1);
          end
        end else begin
          if ((cand_q == {WIDTH{1'b0}}) || (lo_q > hi_dec_s)) begin
            state_d = S_DONE;
            found_d = 1'b0;
            x_d     = {WIDTH{1'b0}};
          end else begin
            hi_d   = hi_dec_s;
            cand_d = WIDTH'((lo_q + hi_dec_s) >> 1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d == S_SEARCH);
    done_d = (state_d == S_DONE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      y_q      <= {WIDTH{1'b0}};
      cand_q   <= {WIDTH{1'b0}};
      lo_q     <= {(WIDTH+1){1'b0}};
      hi_q     <= {(WIDTH+1){1'b0}};
      found_q  <= 1'b0;
      x_q      <= {WIDTH{1'b0}};
      probes_q <= {(WIDTH+1){1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      y_q      <= y_d;
      cand_q   <= cand_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      found_q  <= found_d;
      x_q      <= x_d;
      probes_q <= probes_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign probe_x = cand_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign found   = found_q;
  assign x       = x_q;
  assign probes  = probes_q;

endmodule

// File: tb/tb_invert_search.sv
// Directed bench for invert_search: a linear-mode and a binary-mode instance
// share clock and reset; each sees its own f selected by the bench.
module tb_invert_search;

  logic       clk, rst_n;
  logic       start_l, start_b;
  logic [7:0] y_l, y_b;
  logic [7:0] probe_l, probe_b, f_l, f_b, x_l, x_b;
  logic       busy_l, busy_b, done_l, done_b, found_l, found_b;
  logic [8:0] probes_l, probes_b;
  logic       fsel_l, fsel_b;

  int checks   = 0;
  int failures = 0;

  invert_search #(.WIDTH(8), .MODE(0)) u_lin (
    .clk(clk), .rst_n(rst_n), .start(start_l), .y(y_l), .probe_x(probe_l),
    .f_y(f_l), .busy(busy_l), .done(done_l), .found(found_l), .x(x_l),
    .probes(probes_l)
  );

  invert_search #(.WIDTH(8), .MODE(1)) u_bin (
    .clk(clk), .rst_n(rst_n), .start(start_b), .y(y_b), .probe_x(probe_b),
    .f_y(f_b), .busy(busy_b), .done(done_b), .found(found_b), .x(x_b),
    .probes(probes_b)
  );

  always #5 clk = ~clk;

  // f for the linear instance: 3x+1 or 2x, both mod 256
  always_comb begin
    if (fsel_l) f_l = 8'(probe_l << 1);
    else        f_l = 8'(probe_l * 8'd3 + 8'd1);
  end

  // f for the binary instance: identity or x with bit 0 cleared
  always_comb begin
    if (fsel_b) f_b = {probe_b[7:1], 1'b0};
    else        f_b = probe_b;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One search: start driven on a negedge, outputs sampled on negedges.
  // lat = negedges after the accepting edge until done is seen.
  task automatic run(input bit bin, input logic [7:0] yv, input bit fs, input bit glitch,
                     output int lat, output int bcyc, output bit tmo);
    @(negedge clk);
    check("done_low_before_start", bin ? done_b : done_l, 1'b0);
    if (bin) begin fsel_b = fs; y_b = yv; start_b = 1'b1; end
    else     begin fsel_l = fs; y_l = yv; start_l = 1'b1; end
    @(negedge clk);
    start_l = 1'b0;
    start_b = 1'b0;
    check("cleared_found", bin ? found_b : found_l, 1'b0);
    check("cleared_x", bin ? x_b : x_l, 8'd0);
    lat  = 1;
    bcyc = 0;
    tmo  = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (glitch && lat == 3) begin
        start_l = 1'b1;
        y_l     = 8'h04;
      end else begin
        start_l = 1'b0;
      end
      if (bin ? busy_b : busy_l) bcyc++;
      if (bin ? done_b : done_l) begin
        tmo = 1'b0;
        break;
      end
      @(negedge clk);
      lat++;
    end
    start_l = 1'b0;
    check("no_timeout", tmo, 1'b0);
  endtask

  int lat, bcyc;
  bit tmo;

  initial begin
    clk = 1'b0; rst_n = 1'b0;
    start_l = 1'b0; start_b = 1'b0;
    y_l = 8'd0; y_b = 8'd0;
    fsel_l = 1'b0; fsel_b = 1'b0;

    #3;
    check("rst_probe_x", probe_l, 8'd0);
    check("rst_busy", busy_l, 1'b0);
    check("rst_done", done_b, 1'b0);
    check("rst_probes", probes_b, 9'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // linear 3x+1, y=0x10 -> x=5
    run(1'b0, 8'h10, 1'b0, 1'b0, lat, bcyc, tmo);
    check("lin_found", found_l, 1'b1);
    check("lin_x", x_l, 8'd5);
    check("lin_probes", probes_l, 9'd6);
    check("lin_latency", lat, 7);
    check("lin_busy_cycles", bcyc, 6);

    // start and y change while busy are ignored
    run(1'b0, 8'h10, 1'b0, 1'b1, lat, bcyc, tmo);
    check("ign_x", x_l, 8'd5);
    check("ign_probes", probes_l, 9'd6);

    // back-to-back start in the IDLE cycle right after DONE: 3*2+1=7
    run(1'b0, 8'h07, 1'b0, 1'b0, lat, bcyc, tmo);
    check("b2b_x", x_l, 8'd2);
    check("b2b_probes", probes_l, 9'd3);
    check("b2b_latency", lat, 4);

    // linear 2x, y=3 -> no match, full sweep, candidate stops at 255
    run(1'b0, 8'h03, 1'b1, 1'b0, lat, bcyc, tmo);
    check("nf_found", found_l, 1'b0);
    check("nf_x", x_l, 8'd0);
    check("nf_probes", probes_l, 9'd256);
    check("nf_latency", lat, 257);
    check("nf_probe_nowrap", probe_l, 8'd255);
    check("nf_busy_cycles", bcyc, 256);

    // binary identity, y=200: mids 127,191,223,207,199,203,201,200
    run(1'b1, 8'd200, 1'b0, 1'b0, lat, bcyc, tmo);
    check("bin200_found", found_b, 1'b1);
    check("bin200_x", x_b, 8'd200);
    check("bin200_probes", probes_b, 9'd8);
    check("bin200_latency", lat, 9);

    run(1'b1, 8'd0, 1'b0, 1'b0, lat, bcyc, tmo);
    check("bin0_found", found_b, 1'b1);
    check("bin0_x", x_b, 8'd0);
    check("bin0_probes", probes_b, 9'd8);

    run(1'b1, 8'd255, 1'b0, 1'b0, lat, bcyc, tmo);
    check("bin255_found", found_b, 1'b1);
    check("bin255_x", x_b, 8'd255);
    check("bin255_probes", probes_b, 9'd9);

    // binary, f clears bit 0: y=3 unreachable, y=4 hits at 4 or 5
    run(1'b1, 8'd3, 1'b1, 1'b0, lat, bcyc, tmo);
    check("even3_found", found_b, 1'b0);
    check("even3_x", x_b, 8'd0);
    check("even3_probes", probes_b, 9'd8);

    run(1'b1, 8'd4, 1'b1, 1'b0, lat, bcyc, tmo);
    check("even4_found", found_b, 1'b1);
    check("even4_x_in_set", (x_b == 8'd4) || (x_b == 8'd5), 1'b1);
    check("even4_probes", probes_b, 9'd7);

    // asynchronous reset mid-search
    @(negedge clk);
    fsel_l = 1'b0; y_l = 8'h10; start_l = 1'b1;
    @(negedge clk);
    start_l = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_rst_probe_x", probe_l, 8'd2);
    #2 rst_n = 1'b0;
    #1;
    check("arst_probe_x", probe_l, 8'd0);
    check("arst_busy", busy_l, 1'b0);
    check("arst_probes", probes_l, 9'd0);
    check("arst_found", found_l, 1'b0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("arst_no_done", done_l, 1'b0);
    end
    rst_n = 1'b1;

    run(1'b0, 8'h10, 1'b0, 1'b0, lat, bcyc, tmo);
    check("post_rst_x", x_l, 8'd5);
    check("post_rst_probes", probes_l, 9'd6);
    check("post_rst_found", found_l, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
